ip_codma_ap_sched: RTL and testbench
====================================

IP_CODMA_AP_SCHED -- requirements
Module: ip_codma_ap_sched

Interface
REQ-001 Parameter DEPTH, default 4, number of address-phase FIFO entries (power of two, 2..4).
REQ-002 Ports:
- clk_i  in  1  sole clock; all state updates on its rising edge.
- reset_n_i  in  1  reset; synchronous, active-low.
- stop_i  in  1  flush request.
- rd_req_i  in  1  read-engine address-phase request.
- rd_addr_i  in  32  read address.
- rd_size_i  in  4  read burst size.
- rd_gnt_o  out  1  read request accepted this cycle.
- wr_req_i  in  1  write-engine address-phase request.
- wr_addr_i  in  32  write address.
- wr_size_i  in  4  write burst size.
- wr_gnt_o  out  1  write request accepted this cycle.
- fifo_rd_i  in  1  pop strobe from the address-phase machine.
- ap_fifo_o  out  struct  head entry {addr[31:0], size[3:0], read, write}.
- ap_fifo_count_o  out  3  occupied entries, 0..DEPTH.
- sched_error_o  out  1  sticky protocol error.
REQ-003 The block SHALL have one clock, clk_i, and a synchronous, active-low reset, reset_n_i.

Function
REQ-004 Each requester SHALL use a req/gnt handshake: a transfer occurs in a cycle where req and gnt are both high; gnt SHALL be combinational from the current req, count and priority state.
REQ-005 At most one of rd_gnt_o and wr_gnt_o SHALL be high in any cycle.
REQ-006 A grant SHALL be issued only when ap_fifo_count_o < DEPTH and stop_i is low; no bypass on a same-cycle pop while full.
REQ-007 Arbitration SHALL be round-robin: on contention, grant the requester not granted most recently; after reset, read has priority.
REQ-008 The priority pointer SHALL update only on an actual grant; a lone requester is granted regardless of the pointer.
REQ-009 A granted read SHALL push {rd_addr_i, rd_size_i, read=1, write=0}; a granted write SHALL push {wr_addr_i, wr_size_i, read=0, write=1}.
REQ-010 A pushed entry SHALL appear on ap_fifo_o (if it is the head) and in ap_fifo_count_o one cycle after the grant.
REQ-011 ap_fifo_o SHALL be all-zero when the count is 0; otherwise it SHALL show the oldest entry.
REQ-012 fifo_rd_i with count > 0 SHALL discard the head at the next edge.
REQ-013 A push and a pop in the same cycle SHALL leave the count unchanged and advance both pointers.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH.
REQ-015 fifo_rd_i while the count is 0 SHALL be ignored and SHALL set sched_error_o.
REQ-016 A granted request with size 0 SHALL still be pushed and SHALL set sched_error_o.
REQ-017 stop_i high SHALL, at the next edge, zero the count and both pointers, and leave sched_error_o and the priority pointer unchanged.
REQ-018 stop_i SHALL take precedence over a simultaneous fifo_rd_i; no grant is issued in that cycle.
REQ-019 sched_error_o SHALL clear only on reset.

Reset
REQ-020 While reset_n_i is low at an edge: count = 0, pointers = 0, priority = read, sched_error_o = 0, and both grants low.
REQ-021 Reset mid-operation SHALL discard all queued entries with no further pops honoured; storage contents need not be cleared.

Structure
REQ-022 The entry struct type SHALL live in ip_codma_fifo_pkg, alongside the existing AP FIFO types.
REQ-023 Grant-select enum {GNT_NONE, GNT_RD, GNT_WR} and DEPTH default SHALL live in ip_codma_machine_states_pkg.
REQ-024 Storage SHALL be a single sub-module, ip_codma_ap_fifo (push, pop, flush, count, head); arbitration stays in the top.

Verification
REQ-025 Reset, then rd_req_i=1, rd_addr_i=0x1000, rd_size_i=4 for one cycle -> rd_gnt_o=1 same cycle; next cycle count=1, ap_fifo_o={0x1000,4,1,0}.
REQ-026 rd_req_i and wr_req_i held high for 4 cycles, no pops -> grants alternate RD,WR,RD,WR; count=4; fifth cycle both grants low.
REQ-027 Full FIFO (DEPTH=4), wr_req_i=1 and fifo_rd_i=1 -> no grant that cycle; count=3 next cycle, then a write grant follows; six push/pop pairs exercise pointer wrap with FIFO order preserved.
REQ-028 count=2 with push and pop in the same cycle -> count stays 2; head advances to the second entry.
REQ-029 fifo_rd_i=1 at count=0 -> sched_error_o=1 and stays high; an rd push with size 0 also sets it; only reset_n_i=0 clears it.
REQ-030 count=3, stop_i=1 with rd_req_i=1 and fifo_rd_i=1 -> no grant; next cycle count=0 and ap_fifo_o=0; the priority pointer is unchanged.

Source files
------------

// File: rtl/ip_codma_fifo_pkg.sv
// Address-phase FIFO types shared by the CODMA scheduler and its storage.
package ip_codma_fifo_pkg;

    localparam int AP_ADDR_W  = 32;
    localparam int AP_SIZE_W  = 4;
    localparam int AP_COUNT_W = 3;

    typedef struct packed {
        logic [AP_ADDR_W-1:0] addr;
        logic [AP_SIZE_W-1:0] size;
        logic                 read;
        logic                 write;
    } ap_fifo_entry_t;

    localparam ap_fifo_entry_t AP_FIFO_EMPTY = '0;

endpackage

// File: rtl/ip_codma_machine_states_pkg.sv
// Shared state encodings for the CODMA address-phase machines.
// Holds the scheduler's grant select and the default AP FIFO depth.
package ip_codma_machine_states_pkg;

    localparam int AP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_sel_e;

endpackage

// File: rtl/ip_codma_ap_fifo.sv
// Address-phase entry storage: circular buffer with push, pop, flush and
// a zeroed head while empty. Flush wins over push and pop.
module ip_codma_ap_fifo
    import ip_codma_fifo_pkg::*;
    import ip_codma_machine_states_pkg::*;
#(
    parameter int DEPTH = AP_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  ap_fifo_entry_t        push_data_i,
    input  logic                  pop_i,
    output logic [AP_COUNT_W-1:0] count_o,
    output ap_fifo_entry_t        head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [AP_COUNT_W-1:0] DEPTH_C = AP_COUNT_W'(DEPTH);

    ap_fifo_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [AP_COUNT_W-1:0] count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push_i && (count_q < DEPTH_C) && !flush_i;
    assign pop_ok  = pop_i && (count_q != '0) && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + AP_COUNT_W'(push_ok) - AP_COUNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && reset_n_i) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q == '0) ? AP_FIFO_EMPTY : mem[rd_ptr_q];

endmodule

// File: rtl/ip_codma_ap_sched.sv
// Address-phase scheduler: round-robin req/gnt arbitration between the read
// and write engines feeding a shared AP FIFO, with a sticky protocol error.
module ip_codma_ap_sched
    import ip_codma_fifo_pkg::*;
    import ip_codma_machine_states_pkg::*;
#(
    parameter int DEPTH = AP_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  stop_i,
    input  logic                  rd_req_i,
    input  logic [31:0]           rd_addr_i,
    input  logic [3:0]            rd_size_i,
    output logic                  rd_gnt_o,
    input  logic                  wr_req_i,
    input  logic [31:0]           wr_addr_i,
    input  logic [3:0]            wr_size_i,
    output logic                  wr_gnt_o,
    input  logic                  fifo_rd_i,
    output ap_fifo_entry_t        ap_fifo_o,
    output logic [AP_COUNT_W-1:0] ap_fifo_count_o,
    output logic                  sched_error_o
);

    localparam logic [AP_COUNT_W-1:0] DEPTH_C = AP_COUNT_W'(DEPTH);

    gnt_sel_e       gnt_sel;
    ap_fifo_entry_t push_data;
    logic           can_grant;
    logic           prio_wr_q;
    logic           sched_error_q;
    logic           size_zero;
    logic           underflow;

    assign can_grant = reset_n_i && !stop_i && (ap_fifo_count_o < DEPTH_C);

    // prio_wr_q set means write wins the next contention.
    always_comb begin
        gnt_sel   = GNT_NONE;
        push_data = AP_FIFO_EMPTY;
        if (can_grant) begin
            if (rd_req_i && (!wr_req_i || !prio_wr_q)) begin
                gnt_sel = GNT_RD;
            end else if (wr_req_i) begin
                gnt_sel = GNT_WR;
            end
        end
        case (gnt_sel)
            GNT_RD:  push_data = '{addr: rd_addr_i, size: rd_size_i, read: 1'b1, write: 1'b0};
            GNT_WR:  push_data = '{addr: wr_addr_i, size: wr_size_i, read: 1'b0, write: 1'b1};
            default: push_data = AP_FIFO_EMPTY;
        endcase
    end

    assign rd_gnt_o  = (gnt_sel == GNT_RD);
    assign wr_gnt_o  = (gnt_sel == GNT_WR);
    assign size_zero = (rd_gnt_o && (rd_size_i == '0)) || (wr_gnt_o && (wr_size_i == '0));
    assign underflow = fifo_rd_i && (ap_fifo_count_o == '0);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            prio_wr_q     <= 1'b0;
            sched_error_q <= 1'b0;
        end else begin
            if (rd_gnt_o)      prio_wr_q <= 1'b1;
            else if (wr_gnt_o) prio_wr_q <= 1'b0;
            if (size_zero || underflow) sched_error_q <= 1'b1;
        end
    end

    assign sched_error_o = sched_error_q;

    ip_codma_ap_fifo #(
        .DEPTH (DEPTH)
    ) u_ap_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .flush_i     (stop_i),
        .push_i      (gnt_sel != GNT_NONE),
        .push_data_i (push_data),
        .pop_i       (fifo_rd_i),
        .count_o     (ap_fifo_count_o),
        .head_o      (ap_fifo_o)
    );

endmodule

// File: tb/tb_ip_codma_ap_sched.sv
// Directed bench for the CODMA address-phase scheduler and its FIFO.
module tb_ip_codma_ap_sched;
    import ip_codma_fifo_pkg::*;

    logic           clk_i = 1'b0;
    logic           reset_n_i = 1'b0;
    logic           stop_i = 1'b0;
    logic           rd_req_i = 1'b0;
    logic [31:0]    rd_addr_i = '0;
    logic [3:0]     rd_size_i = '0;
    logic           rd_gnt_o;
    logic           wr_req_i = 1'b0;
    logic [31:0]    wr_addr_i = '0;
    logic [3:0]     wr_size_i = '0;
    logic           wr_gnt_o;
    logic           fifo_rd_i = 1'b0;
    ap_fifo_entry_t ap_fifo_o;
    logic [2:0]     ap_fifo_count_o;
    logic           sched_error_o;

    int n_cmp = 0;
    int n_fail = 0;
    ap_fifo_entry_t exp_q[$];
    ap_fifo_entry_t e;

    always #5 clk_i = ~clk_i;

    ip_codma_ap_sched #(.DEPTH(4)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .stop_i          (stop_i),
        .rd_req_i        (rd_req_i),
        .rd_addr_i       (rd_addr_i),
        .rd_size_i       (rd_size_i),
        .rd_gnt_o        (rd_gnt_o),
        .wr_req_i        (wr_req_i),
        .wr_addr_i       (wr_addr_i),
        .wr_size_i       (wr_size_i),
        .wr_gnt_o        (wr_gnt_o),
        .fifo_rd_i       (fifo_rd_i),
        .ap_fifo_o       (ap_fifo_o),
        .ap_fifo_count_o (ap_fifo_count_o),
        .sched_error_o   (sched_error_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        stop_i = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0; fifo_rd_i = 1'b0;
        rd_addr_i = '0; rd_size_i = '0; wr_addr_i = '0; wr_size_i = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        reset_n_i = 1'b0;
        rd_req_i = 1'b1; wr_req_i = 1'b1; rd_size_i = 4'd2; wr_size_i = 4'd2;
        tick();
        tick();
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt got %b want 00", {rd_gnt_o, wr_gnt_o});
        end
        idle();
        reset_n_i = 1'b1;
        #1;
        n_cmp++;
        if (ap_fifo_count_o !== 3'd0 || ap_fifo_o !== 38'h0 || sched_error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got cnt=%0d head=%h err=%b want 0/0/0",
                     ap_fifo_count_o, ap_fifo_o, sched_error_o);
        end
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        rd_req_i = 1'b1; rd_addr_i = 32'h1000; rd_size_i = 4'd4;
        #1;
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL single_rd_gnt got %b want 10", {rd_gnt_o, wr_gnt_o});
        end
        tick();
        idle();
        n_cmp++;
        if (ap_fifo_count_o !== 3'd1 || ap_fifo_o !== {32'h1000, 4'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rd_entry got cnt=%0d head=%h want 1/%h",
                     ap_fifo_count_o, ap_fifo_o, {32'h1000, 4'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd_req_i = 1'b1; rd_addr_i = 32'hA000 + i; rd_size_i = 4'd1;
            wr_req_i = 1'b1; wr_addr_i = 32'hB000 + i; wr_size_i = 4'd2;
            #1;
            n_cmp++;
            if ({rd_gnt_o, wr_gnt_o} !== exp_gnt[i]) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d] got %b want %b", i, {rd_gnt_o, wr_gnt_o}, exp_gnt[i]);
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o} !== 2'b00 || ap_fifo_count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL rr_full got gnt=%b cnt=%0d want 00/4", {rd_gnt_o, wr_gnt_o}, ap_fifo_count_o);
        end
        idle();
        tick();
        // Entries in order: RD A000, WR B001, RD A002, WR B003.
        for (int i = 0; i < 4; i++) begin
            e.addr  = (i % 2 == 0) ? 32'hA000 + i : 32'hB000 + i;
            e.size  = (i % 2 == 0) ? 4'd1 : 4'd2;
            e.read  = (i % 2 == 0);
            e.write = (i % 2 == 1);
            n_cmp++;
            if (ap_fifo_o !== e) begin
                n_fail++; $display("FAIL rr_order[%0d] got %h want %h", i, ap_fifo_o, e);
            end
            fifo_rd_i = 1'b1;
            tick();
        end
        fifo_rd_i = 1'b0;
        n_cmp++;
        if (ap_fifo_count_o !== 3'd0 || ap_fifo_o !== 38'h0) begin
            n_fail++; $display("FAIL rr_drain got cnt=%0d head=%h want 0/0", ap_fifo_count_o, ap_fifo_o);
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [3:0] size);
        wr_req_i = 1'b1; wr_addr_i = addr; wr_size_i = size;
        e.addr = addr; e.size = size; e.read = 1'b0; e.write = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic test_full_and_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_wr(32'h100 + i, 4'(i + 1));
            tick();
        end
        wr_req_i = 1'b0;
        wr_req_i = 1'b1; wr_addr_i = 32'h104; wr_size_i = 4'd5; fifo_rd_i = 1'b1;
        #1;
        n_cmp++;
        if (wr_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL full_no_bypass got wr_gnt=%b want 0", wr_gnt_o);
        end
        tick();
        void'(exp_q.pop_front());
        fifo_rd_i = 1'b0;
        n_cmp++;
        if (ap_fifo_count_o !== 3'd3 || ap_fifo_o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL full_pop got cnt=%0d head=%h want 3/%h", ap_fifo_count_o, ap_fifo_o, exp_q[0]);
        end
        push_wr(32'h104, 4'd5);
        #1;
        n_cmp++;
        if (wr_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL full_regrant got wr_gnt=%b want 1", wr_gnt_o);
        end
        tick();
        wr_req_i = 1'b0; fifo_rd_i = 1'b1;
        tick();
        void'(exp_q.pop_front());
        for (int i = 0; i < 6; i++) begin
            push_wr(32'h105 + i, 4'(i + 6));
            fifo_rd_i = 1'b1;
            #1;
            n_cmp++;
            if (wr_gnt_o !== 1'b1) begin
                n_fail++; $display("FAIL wrap_gnt[%0d] got %b want 1", i, wr_gnt_o);
            end
            tick();
            void'(exp_q.pop_front());
            n_cmp++;
            if (ap_fifo_count_o !== 3'd3 || ap_fifo_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL wrap_pair[%0d] got cnt=%0d head=%h want 3/%h",
                         i, ap_fifo_count_o, ap_fifo_o, exp_q[0]);
            end
        end
        wr_req_i = 1'b0;
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (ap_fifo_o !== exp_q[0]) begin
                n_fail++; $display("FAIL wrap_drain got %h want %h", ap_fifo_o, exp_q[0]);
            end
            fifo_rd_i = 1'b1;
            tick();
            void'(exp_q.pop_front());
        end
        idle();
    endtask

    task automatic test_back_to_back_push_pop();
        do_reset();
        rd_req_i = 1'b1; rd_size_i = 4'd3;
        rd_addr_i = 32'h200; tick();
        rd_addr_i = 32'h201; tick();
        rd_addr_i = 32'h202; fifo_rd_i = 1'b1;
        tick();
        idle();
        n_cmp++;
        if (ap_fifo_count_o !== 3'd2 || ap_fifo_o !== {32'h201, 4'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pushpop got cnt=%0d head=%h want 2/%h",
                     ap_fifo_count_o, ap_fifo_o, {32'h201, 4'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_error();
        do_reset();
        fifo_rd_i = 1'b1;
        tick();
        fifo_rd_i = 1'b0;
        n_cmp++;
        if (sched_error_o !== 1'b1 || ap_fifo_count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL err_underflow got err=%b cnt=%0d want 1/0", sched_error_o, ap_fifo_count_o);
        end
        tick(); tick();
        n_cmp++;
        if (sched_error_o !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got %b want 1", sched_error_o);
        end
        do_reset();
        n_cmp++;
        if (sched_error_o !== 1'b0) begin
            n_fail++; $display("FAIL err_reset_clear got %b want 0", sched_error_o);
        end
        rd_req_i = 1'b1; rd_addr_i = 32'h300; rd_size_i = 4'd0;
        tick();
        idle();
        n_cmp++;
        if (sched_error_o !== 1'b1 || ap_fifo_count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL err_size0 got err=%b cnt=%0d want 1/1", sched_error_o, ap_fifo_count_o);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_cmp++;
        if (sched_error_o !== 1'b1 || ap_fifo_count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL err_stop_keep got err=%b cnt=%0d want 1/0", sched_error_o, ap_fifo_count_o);
        end
        do_reset();
        n_cmp++;
        if (sched_error_o !== 1'b0) begin
            n_fail++; $display("FAIL err_final_clear got %b want 0", sched_error_o);
        end
    endtask

    task automatic test_stop();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rd_req_i = 1'b1; rd_addr_i = 32'h400 + i; rd_size_i = 4'd1;
            wr_req_i = 1'b1; wr_addr_i = 32'h500 + i; wr_size_i = 4'd1;
            tick();
        end
        wr_req_i = 1'b0;
        n_cmp++;
        if (ap_fifo_count_o !== 3'd3) begin
            n_fail++; $display("FAIL stop_setup got cnt=%0d want 3", ap_fifo_count_o);
        end
        stop_i = 1'b1; rd_req_i = 1'b1; fifo_rd_i = 1'b1;
        #1;
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o} !== 2'b00) begin
            n_fail++; $display("FAIL stop_gnt got %b want 00", {rd_gnt_o, wr_gnt_o});
        end
        tick();
        idle();
        n_cmp++;
        if (ap_fifo_count_o !== 3'd0 || ap_fifo_o !== 38'h0) begin
            n_fail++; $display("FAIL stop_flush got cnt=%0d head=%h want 0/0", ap_fifo_count_o, ap_fifo_o);
        end
        // Last grant before stop was a read, so write must still win.
        rd_req_i = 1'b1; wr_req_i = 1'b1; rd_size_i = 4'd1; wr_size_i = 4'd1;
        #1;
        n_cmp++;
        if ({rd_gnt_o, wr_gnt_o} !== 2'b01) begin
            n_fail++; $display("FAIL stop_prio got %b want 01", {rd_gnt_o, wr_gnt_o});
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_full_and_wrap();
        test_back_to_back_push_pop();
        test_error();
        test_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
